// File: rtl/game_sprite_sequencer.sv
// Lifecycle controller for one sprite: spawn, flight, off-screen/collision handling, respawn delay, lives and game-over.
// Optional macro GAME_SPRITE_SEQUENCER_RANDOM_Y_EN randomises the spawn y with an 8-bit LFSR.
module game_sprite_sequencer #(
  parameter int DX_WIDTH      = 2,
  parameter int DY_WIDTH      = 1,
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter int start_x       = 0,
  parameter int start_y       = 240,
  parameter int start_dx      = 1,
  parameter int start_dy      = 0,
  parameter int respawn_delay = 1000000,
  parameter int max_lives     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                launch,
  input  logic                collision,
  input  logic [w_x-1:0]      sprite_x,
  input  logic [w_y-1:0]      sprite_y,
  output logic                sprite_write_xy,
  output logic                sprite_write_dxy,
  output logic [w_x-1:0]      sprite_write_x,
  output logic [w_y-1:0]      sprite_write_y,
  output logic [DX_WIDTH-1:0] sprite_write_dx,
  output logic [DY_WIDTH-1:0] sprite_write_dy,
  output logic                sprite_enable_update,
  output logic                sprite_active,
  output logic [3:0]          lives,
  output logic                game_over
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DELAY, OVER} state_t;

  localparam int CW = (respawn_delay > 1) ? $clog2(respawn_delay) : 1;
  // One extra bit so a screen size equal to 2**w still compares correctly.
  localparam logic [w_x:0] SCR_W = screen_width[w_x:0];
  localparam logic [w_y:0] SCR_H = screen_height[w_y:0];

  state_t         state_q, state_d;
  logic [3:0]     lives_q, lives_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           off_screen;

  assign off_screen = ({1'b0, sprite_x} >= SCR_W) || ({1'b0, sprite_y} >= SCR_H);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lives_q <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, OVER: begin
        if (launch) begin
          state_d = LOAD;
          lives_d = 4'(max_lives);
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // Collision outranks off-screen; reaching zero lives skips the delay.
        if (collision) begin
          lives_d = lives_q - 4'd1;
          state_d = (lives_q == 4'd1) ? OVER : DELAY;
          cnt_d   = CW'(respawn_delay - 1);
        end else if (off_screen) begin
          state_d = DELAY;
          cnt_d   = CW'(respawn_delay - 1);
        end
      end
      DELAY: begin
        if (cnt_q == '0) state_d = LOAD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sprite_write_xy      = (state_q == LOAD);
  assign sprite_write_dxy     = (state_q == LOAD);
  assign sprite_enable_update = (state_q == RUN);
  assign sprite_active        = (state_q == RUN);
  assign game_over            = (state_q == OVER);
  assign lives                = lives_q;
  assign sprite_write_x       = w_x'(start_x);
  assign sprite_write_dx      = DX_WIDTH'(start_dx);
  assign sprite_write_dy      = DY_WIDTH'(start_dy);

`ifdef GAME_SPRITE_SEQUENCER_RANDOM_Y_EN
  logic [7:0]     lfsr_q;
  logic [w_y-1:0] y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'h01;
      y_q    <= w_y'(start_y);
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      // Latch on the transition into LOAD so y is stable for the whole strobe.
      if (state_d == LOAD && state_q != LOAD)
        y_q <= w_y'(start_y + int'(lfsr_q[6:0]));
    end
  end

  assign sprite_write_y = y_q;
`else
  assign sprite_write_y = w_y'(start_y);
`endif

endmodule
